// File: rtl/ml_qspi_ctrl.sv
// Quad-SPI slave command controller: pad sequencing, command decode, buffer/core bridge.
// Optional frame timeout when ML_QSPI_TIMEOUT_EN is defined.
module ml_qspi_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ml_clk_i,
    input  logic              ml_csb_i,
    input  logic [3:0]        ml_io_di,
    output logic [3:0]        ml_io_do,
    output logic [3:0]        ml_io_oe,
    output logic              ml_rdy,
    output logic              ml_err,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              buf_wen,
    output logic              buf_ren,
    input  logic [7:0]        buf_rdata,
    output logic              core_start,
    input  logic              core_busy
);

    localparam int ADDR_BYTES = ADDR_W / 8;

    if ((ADDR_W != 8 && ADDR_W != 16) || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("ml_qspi_ctrl: unsupported parameter values");
    end

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, WDATA, TURN, RDATA, STAT, CMD_DONE, DISCARD
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_WRITE, OP_READ, OP_START, OP_STATUS, OP_CLR
    } op_t;

    state_t state;
    op_t    op;

    logic [1:0]        clk_sync;
    logic [1:0]        csb_sync;
    logic [3:0]        di_sync0;
    logic [3:0]        di_sync1;
    logic              clk_last;
    logic              csb_last;

    logic              have_hi;
    logic [3:0]        hi_nib;
    logic              abyte;
    logic              turn_cnt;
    logic              out_lo;
    logic              ren_last;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] addr;
    logic              err;

    logic              clk_rise;
    logic              clk_fall;
    logic              csb_rise;
    logic              csb_fall;
    logic              byte_done;
    logic [7:0]        byte_val;
    logic [ADDR_W+7:0] addr_shift;
    logic [ADDR_W-1:0] addr_next;
    logic              err_set;
    logic              err_clr;
    logic              timeout;

`ifdef ML_QSPI_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b00;
            csb_sync <= 2'b11;
            di_sync0 <= 4'h0;
            di_sync1 <= 4'h0;
            clk_last <= 1'b0;
            csb_last <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ml_clk_i};
            csb_sync <= {csb_sync[0], ml_csb_i};
            di_sync0 <= ml_io_di;
            di_sync1 <= di_sync0;
            clk_last <= clk_sync[1];
            csb_last <= csb_sync[1];
        end
    end

    always_comb begin
        clk_rise   = clk_sync[1] & ~clk_last;
        clk_fall   = ~clk_sync[1] & clk_last;
        csb_rise   = csb_sync[1] & ~csb_last;
        csb_fall   = ~csb_sync[1] & csb_last;
        byte_done  = clk_rise & have_hi;
        byte_val   = {hi_nib, di_sync1};
        addr_shift = {addr, byte_val};
        addr_next  = addr_shift[ADDR_W-1:0];
    end

`ifdef ML_QSPI_TIMEOUT_EN
    always_comb begin
        timeout = (to_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !clk_rise && !clk_fall &&
                  (state != IDLE) && (state != DISCARD);
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    // A set and a clear landing in the same cycle resolve to set.
    always_comb begin
        err_set = 1'b0;
        err_clr = 1'b0;
        if (csb_rise) begin
            if (state == CMD_DONE && op == OP_START && core_busy)
                err_set = 1'b1;
            if (state == CMD_DONE && op == OP_CLR)
                err_clr = 1'b1;
        end else if (timeout) begin
            err_set = 1'b1;
        end else if (byte_done) begin
            if (state == CMD && !(byte_val inside {[8'h01:8'h05]}))
                err_set = 1'b1;
            if (state == WDATA && core_busy)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            op         <= OP_NONE;
            have_hi    <= 1'b0;
            hi_nib     <= 4'h0;
            abyte      <= 1'b0;
            turn_cnt   <= 1'b0;
            out_lo     <= 1'b0;
            ren_last   <= 1'b0;
            rd_byte    <= 8'h00;
            addr       <= '0;
            err        <= 1'b0;
            ml_io_do   <= 4'h0;
            ml_io_oe   <= 4'h0;
            ml_rdy     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= 8'h00;
            buf_wen    <= 1'b0;
            buf_ren    <= 1'b0;
            core_start <= 1'b0;
`ifdef ML_QSPI_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            buf_wen    <= 1'b0;
            buf_ren    <= 1'b0;
            core_start <= 1'b0;
            ml_rdy     <= ~core_busy;
            err        <= err_set | (err & ~err_clr);
            ren_last   <= buf_ren;
            if (ren_last)
                rd_byte <= buf_rdata;
`ifdef ML_QSPI_TIMEOUT_EN
            if (state == IDLE || state == DISCARD || clk_rise || clk_fall)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + CNT_W'(1);
`endif
            if (csb_rise) begin
                state    <= IDLE;
                ml_io_oe <= 4'h0;
                ml_io_do <= 4'h0;
                have_hi  <= 1'b0;
                if (state == CMD_DONE && op == OP_START && !core_busy)
                    core_start <= 1'b1;
            end else if (timeout) begin
                state    <= DISCARD;
                ml_io_oe <= 4'h0;
                ml_io_do <= 4'h0;
            end else begin
                if (clk_rise) begin
                    have_hi <= ~have_hi;
                    hi_nib  <= di_sync1;
                end
                unique case (state)
                    IDLE: begin
                        have_hi <= 1'b0;
                        abyte   <= 1'b0;
                        op      <= OP_NONE;
                        if (csb_fall)
                            state <= CMD;
                    end
                    CMD: begin
                        if (byte_done) begin
                            case (byte_val)
                                8'h01: begin op <= OP_WRITE;  state <= ADDR;     end
                                8'h02: begin op <= OP_READ;   state <= ADDR;     end
                                8'h03: begin op <= OP_START;  state <= CMD_DONE; end
                                8'h04: begin
                                    op       <= OP_STATUS;
                                    state    <= TURN;
                                    turn_cnt <= 1'b0;
                                    out_lo   <= 1'b0;
                                end
                                8'h05: begin op <= OP_CLR;    state <= CMD_DONE; end
                                default: state <= DISCARD;
                            endcase
                        end
                    end
                    ADDR: begin
                        if (byte_done) begin
                            addr <= addr_next;
                            if (abyte == 1'(ADDR_BYTES - 1)) begin
                                abyte <= 1'b0;
                                if (op == OP_READ) begin
                                    buf_ren  <= 1'b1;
                                    buf_addr <= addr_next;
                                    state    <= TURN;
                                    turn_cnt <= 1'b0;
                                    out_lo   <= 1'b0;
                                end else begin
                                    state <= WDATA;
                                end
                            end else begin
                                abyte <= 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (byte_done) begin
                            if (!core_busy) begin
                                buf_wen   <= 1'b1;
                                buf_wdata <= byte_val;
                                buf_addr  <= addr;
                            end
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                    TURN: begin
                        if (clk_rise) begin
                            if (turn_cnt) begin
                                state    <= (op == OP_READ) ? RDATA : STAT;
                                ml_io_oe <= 4'hF;
                            end else begin
                                turn_cnt <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        // Prefetch the next byte while its predecessor's low nibble is on the pads.
                        if (clk_fall) begin
                            if (!out_lo) begin
                                ml_io_do <= rd_byte[7:4];
                                out_lo   <= 1'b1;
                            end else begin
                                ml_io_do <= rd_byte[3:0];
                                out_lo   <= 1'b0;
                                buf_ren  <= 1'b1;
                                buf_addr <= addr + ADDR_W'(1);
                                addr     <= addr + ADDR_W'(1);
                            end
                        end
                    end
                    STAT: begin
                        if (clk_fall) begin
                            ml_io_do <= out_lo ? {2'b00, err, core_busy} : 4'h0;
                            out_lo   <= ~out_lo;
                        end
                    end
                    CMD_DONE: begin
                    end
                    DISCARD: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ml_err = err;

endmodule

// File: tb/tb_ml_qspi_ctrl.sv
// Scoreboard bench for ml_qspi_ctrl: host-side QSPI driver, buffer model, write/nibble queues.
// Timeout scenario runs only when ML_QSPI_TIMEOUT_EN is defined.
module tb_ml_qspi_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ml_clk_i = 1'b0;
    logic        ml_csb_i = 1'b1;
    logic [3:0]  ml_io_di = 4'h0;
    logic [3:0]  ml_io_do;
    logic [3:0]  ml_io_oe;
    logic        ml_rdy;
    logic        ml_err;
    logic [15:0] buf_addr;
    logic [7:0]  buf_wdata;
    logic        buf_wen;
    logic        buf_ren;
    logic [7:0]  buf_rdata = 8'h00;
    logic        core_start;
    logic        core_busy = 1'b0;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] nq[$];
    logic [7:0] mem [0:65535];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_start = 0;

    always #5 clock = ~clock;

    ml_qspi_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .resetn(resetn),
        .ml_clk_i(ml_clk_i), .ml_csb_i(ml_csb_i),
        .ml_io_di(ml_io_di), .ml_io_do(ml_io_do), .ml_io_oe(ml_io_oe),
        .ml_rdy(ml_rdy), .ml_err(ml_err),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_wen(buf_wen), .buf_ren(buf_ren), .buf_rdata(buf_rdata),
        .core_start(core_start), .core_busy(core_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clock)
        if (buf_ren) buf_rdata <= mem[buf_addr];

    always @(negedge clock) begin
        if (resetn && buf_wen) begin
            check("wen_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
                wr_t w;
                w = wq.pop_front();
                check("wen_addr", 32'(buf_addr), 32'(w.a));
                check("wen_data", 32'(buf_wdata), 32'(w.d));
            end
        end
        if (resetn && core_start) n_start++;
    end

    task automatic send_nib(input logic [3:0] n);
        ml_io_di = n;
        #80 ml_clk_i = 1'b1;
        #80 ml_clk_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    task automatic turn_nib();
        #80 check("turn_oe", 32'(ml_io_oe), 32'h0);
        ml_clk_i = 1'b1;
        #80 ml_clk_i = 1'b0;
    endtask

    task automatic recv_nib(input string tag);
        logic [3:0] e;
        #80;
        check({tag, "_avail"}, 32'(nq.size() != 0), 32'd1);
        e = (nq.size() != 0) ? nq.pop_front() : 4'h0;
        check(tag, 32'(ml_io_do), 32'(e));
        check({tag, "_oe"}, 32'(ml_io_oe), 32'hF);
        ml_clk_i = 1'b1;
        #80 ml_clk_i = 1'b0;
    endtask

    task automatic frame_begin();
        ml_csb_i = 1'b0;
        #80;
    endtask

    task automatic frame_end();
        #80 ml_csb_i = 1'b1;
        #200;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 1);
        mem[16'hFFFF] = 8'h3C;
        mem[16'h0000] = 8'hC3;

        #23;
        check("rst_rdy", 32'(ml_rdy), 32'd0);
        check("rst_oe", 32'(ml_io_oe), 32'h0);
        check("rst_do", 32'(ml_io_do), 32'h0);
        check("rst_err", 32'(ml_err), 32'd0);
        check("rst_wen", 32'({buf_wen, buf_ren, core_start}), 32'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check("rdy_idle", 32'(ml_rdy), 32'd1);

        // write two bytes from 0x0010
        wq.push_back('{a: 16'h0010, d: 8'hAA});
        wq.push_back('{a: 16'h0011, d: 8'h55});
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'hAA); send_byte(8'h55);
        frame_end();
        check("wr_drain", 32'(wq.size()), 32'd0);

        // read across the address wrap
        nq.push_back(mem[16'hFFFF][7:4]);
        nq.push_back(mem[16'hFFFF][3:0]);
        nq.push_back(mem[16'h0000][7:4]);
        nq.push_back(mem[16'h0000][3:0]);
        frame_begin();
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
        turn_nib(); turn_nib();
        recv_nib("rd_n0"); recv_nib("rd_n1");
        recv_nib("rd_n2"); recv_nib("rd_n3");
        frame_end();
        check("rd_oe_off", 32'(ml_io_oe), 32'h0);

        // start while idle, trailing byte ignored
        frame_begin();
        send_byte(8'h03); send_byte(8'hAA);
        frame_end();
        check("start_cnt", 32'(n_start), 32'd1);
        check("start_err", 32'(ml_err), 32'd0);

        // start while busy
        core_busy = 1'b1;
        repeat (2) @(negedge clock);
        check("rdy_busy", 32'(ml_rdy), 32'd0);
        frame_begin();
        send_byte(8'h03);
        frame_end();
        check("busy_start_cnt", 32'(n_start), 32'd1);
        check("busy_start_err", 32'(ml_err), 32'd1);

        nq.push_back(4'h0);
        nq.push_back(4'h3);
        frame_begin();
        send_byte(8'h04);
        turn_nib(); turn_nib();
        recv_nib("stat_hi"); recv_nib("stat_lo");
        frame_end();
        core_busy = 1'b0;

        frame_begin();
        send_byte(8'h05); send_byte(8'hFF);
        frame_end();
        check("clr_err", 32'(ml_err), 32'd0);

        // illegal opcode
        frame_begin();
        send_byte(8'h7E); send_byte(8'h12);
        frame_end();
        check("bad_op_err", 32'(ml_err), 32'd1);
        frame_begin();
        send_byte(8'h05);
        frame_end();
        check("bad_op_clr", 32'(ml_err), 32'd0);

        // frame aborted mid-byte
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
        send_nib(4'hA);
        frame_end();
        check("abort_oe", 32'(ml_io_oe), 32'h0);
        wq.push_back('{a: 16'h0030, d: 8'h5A});
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
        send_byte(8'h5A);
        frame_end();
        check("abort_next_drain", 32'(wq.size()), 32'd0);

        // write while core busy
        core_busy = 1'b1;
        frame_begin();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h11); send_byte(8'h22);
        frame_end();
        core_busy = 1'b0;
        check("busy_wr_err", 32'(ml_err), 32'd1);
        frame_begin();
        send_byte(8'h05);
        frame_end();
        check("busy_wr_clr", 32'(ml_err), 32'd0);

        // write address wraps
        wq.push_back('{a: 16'hFFFF, d: 8'h12});
        wq.push_back('{a: 16'h0000, d: 8'h34});
        frame_begin();
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
        send_byte(8'h12); send_byte(8'h34);
        frame_end();
        check("wrap_drain", 32'(wq.size()), 32'd0);

`ifdef ML_QSPI_TIMEOUT_EN
        ml_csb_i = 1'b0;
        repeat (25) @(negedge clock);
        check("to_err", 32'(ml_err), 32'd1);
        send_byte(8'h05);
        frame_end();
        check("to_discard", 32'(ml_err), 32'd1);
        frame_begin();
        send_byte(8'h05);
        frame_end();
        check("to_clr", 32'(ml_err), 32'd0);
`endif

        check("final_wq", 32'(wq.size()), 32'd0);
        check("final_nq", 32'(nq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
